// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-code names, rate table helpers and the
// baud-generator FSM state encoding.
package uart_pkg;

  localparam logic [3:0] BPS_600    = 4'h0;
  localparam logic [3:0] BPS_1200   = 4'h1;
  localparam logic [3:0] BPS_1800   = 4'h2;
  localparam logic [3:0] BPS_2400   = 4'h3;
  localparam logic [3:0] BPS_3600   = 4'h4;
  localparam logic [3:0] BPS_4800   = 4'h5;
  localparam logic [3:0] BPS_7200   = 4'h6;
  localparam logic [3:0] BPS_9600   = 4'h7;
  localparam logic [3:0] BPS_19200  = 4'h8;
  localparam logic [3:0] BPS_38400  = 4'h9;
  localparam logic [3:0] BPS_14400  = 4'hA;
  localparam logic [3:0] BPS_28800  = 4'hB;
  localparam logic [3:0] BPS_57600  = 4'hC;
  localparam logic [3:0] BPS_76800  = 4'hD;
  localparam logic [3:0] BPS_115200 = 4'hE;
  localparam logic [3:0] BPS_230400 = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } bps_state_e;

  function automatic int unsigned bps_of(input logic [3:0] code);
    case (code)
      BPS_600:    return 600;
      BPS_1200:   return 1200;
      BPS_1800:   return 1800;
      BPS_2400:   return 2400;
      BPS_3600:   return 3600;
      BPS_4800:   return 4800;
      BPS_7200:   return 7200;
      BPS_9600:   return 9600;
      BPS_19200:  return 19200;
      BPS_38400:  return 38400;
      BPS_14400:  return 14400;
      BPS_28800:  return 28800;
      BPS_57600:  return 57600;
      BPS_76800:  return 76800;
      BPS_115200: return 115200;
      default:    return 230400;
    endcase
  endfunction

  function automatic logic [15:0] div_of(input logic [3:0] code, input int unsigned clk_freq);
    int unsigned d;
    d = clk_freq / bps_of(code);
    return (d > 32'h0000_FFFF) ? 16'hFFFF : d[15:0];
  endfunction

  // Rounded phase increment; evaluated only on constants, never in hardware.
  function automatic logic [31:0] inc_of(input logic [3:0] code, input int unsigned clk_freq,
                                         input int unsigned os, input int unsigned acc_w);
    longint unsigned num;
    num = (64'(bps_of(code)) * 64'(os)) << acc_w;
    return 32'((2 * num + 64'(clk_freq)) / (2 * 64'(clk_freq)));
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Oversample/bit tick generator. UART_BAUD_FRAC_EN selects the fractional
// phase accumulator; otherwise an integer down-counter sets the tick period.
module uart_baud_nco #(
  parameter int unsigned OVERSAMPLE = 16
`ifdef UART_BAUD_FRAC_EN
  , parameter int unsigned ACC_W    = 24
`else
  , parameter logic [15:0] RST_RELOAD = 16'd13
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
`ifdef UART_BAUD_FRAC_EN
  input  logic [ACC_W-1:0] inc,
`else
  input  logic [15:0]      reload,
`endif
  output logic             tick_os,
  output logic             tick_bit
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic            evt;
  logic [OS_W-1:0] os_cnt;
  logic            os_wrap;

`ifdef UART_BAUD_FRAC_EN
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // The carry out of the add is the oversample event.
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign evt = sum[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= sum[ACC_W-1:0];
  end
`else
  logic [15:0] cnt;

  assign evt = (cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= RST_RELOAD;
    else if (clear)  cnt <= reload;
    else if (enable) cnt <= evt ? reload : cnt - 16'd1;
  end
`endif

  assign os_wrap = (os_cnt == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
    end else if (clear) begin
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_bit <= 1'b0;
    end else begin
      tick_os  <= enable && evt;
      tick_bit <= enable && evt && os_wrap;
      if (enable && evt) os_cnt <= os_wrap ? '0 : os_cnt + OS_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: code lookup, deferred rate-change FSM and tick
// generator. UART_BAUD_FRAC_EN selects the fractional NCO in uart_baud_nco.
//   state | meaning
//   RUN   | active code in use, no change requested
//   WAIT  | change requested, waiting for line_idle
//   APPLY | one cycle: switch code, clear tick phase, pulse bps_ack
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 27000000,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned ACC_W        = 24,
  parameter logic [3:0]  DEFAULT_CODE = 4'b1110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_bps,
  input  logic        bps_update,
  input  logic        line_idle,
  input  logic        enable,
  output logic [15:0] bps_cnt_data,
  output logic        tick_os,
  output logic        tick_bit,
  output logic        bps_pending,
  output logic        bps_ack
);

  localparam logic [15:0] DEF_DIV = div_of(DEFAULT_CODE, CLK_FREQ);

  bps_state_e  state;
  logic [3:0]  act_code;
  logic [3:0]  pend_code;
  logic [3:0]  step_code;
  logic        to_apply;
  logic        nco_clear;
  logic        unused_cfg;
  logic [15:0] div_tab [16];

  assign unused_cfg = ^uart_bps[7:4] ^ (ACC_W > 0);

`ifdef UART_BAUD_FRAC_EN
  logic [ACC_W-1:0] inc_tab [16];
`else
  localparam logic [15:0] DEF_RLD = (DEF_DIV < 16'(OVERSAMPLE)) ? 16'd0
                                    : 16'(DEF_DIV / 16'(OVERSAMPLE)) - 16'd1;
  logic [15:0] rld_tab [16];
`endif

  for (genvar g = 0; g < 16; g++) begin : g_tab
    localparam logic [15:0] DIV_G = div_of(4'(g), CLK_FREQ);
    assign div_tab[g] = DIV_G;
`ifdef UART_BAUD_FRAC_EN
    assign inc_tab[g] = ACC_W'(inc_of(4'(g), CLK_FREQ, OVERSAMPLE, ACC_W));
`else
    assign rld_tab[g] = (DIV_G < 16'(OVERSAMPLE)) ? 16'd0
                        : 16'(DIV_G / 16'(OVERSAMPLE)) - 16'd1;
`endif
  end

  // Clear spans the edge into APPLY and the APPLY edge itself, so no tick
  // shows during APPLY and counting restarts from zero on the new rate.
  assign to_apply  = line_idle && ((state == RUN && bps_update) || state == WAIT);
  assign nco_clear = to_apply || (state == APPLY);
  assign step_code = (state == APPLY) ? pend_code : act_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      act_code     <= DEFAULT_CODE;
      pend_code    <= DEFAULT_CODE;
      bps_cnt_data <= DEF_DIV;
      bps_pending  <= 1'b0;
      bps_ack      <= 1'b0;
    end else begin
      bps_ack <= 1'b0;
      case (state)
        RUN: begin
          if (bps_update) begin
            pend_code <= uart_bps[3:0];
            if (line_idle) begin
              state   <= APPLY;
              bps_ack <= 1'b1;
            end else begin
              state       <= WAIT;
              bps_pending <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bps_update) pend_code <= uart_bps[3:0];
          if (line_idle) begin
            state       <= APPLY;
            bps_ack     <= 1'b1;
            bps_pending <= 1'b0;
          end
        end
        APPLY: begin
          act_code     <= pend_code;
          bps_cnt_data <= div_tab[pend_code];
          state        <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef UART_BAUD_FRAC_EN
  uart_baud_nco #(
    .OVERSAMPLE (OVERSAMPLE),
    .ACC_W      (ACC_W)
  ) u_nco (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (nco_clear),
    .inc      (inc_tab[step_code]),
    .tick_os  (tick_os),
    .tick_bit (tick_bit)
  );
`else
  uart_baud_nco #(
    .OVERSAMPLE (OVERSAMPLE),
    .RST_RELOAD (DEF_RLD)
  ) u_nco (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (nco_clear),
    .reload   (rld_tab[step_code]),
    .tick_os  (tick_os),
    .tick_bit (tick_bit)
  );
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen; the reference model predicts ticks
// from the number of enabled clocks since the last phase origin.
module tb_uart_baud_gen;

  localparam int unsigned CLK_FREQ = 27000000;
  localparam int unsigned OS       = 16;
  localparam int unsigned ACC_W    = 24;
  localparam logic [3:0]  DEF      = 4'hE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  uart_bps = 8'h00;
  logic        bps_update = 1'b0;
  logic        line_idle = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] bps_cnt_data;
  logic        tick_os;
  logic        tick_bit;
  logic        bps_pending;
  logic        bps_ack;

  uart_baud_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_bps     (uart_bps),
    .bps_update   (bps_update),
    .line_idle    (line_idle),
    .enable       (enable),
    .bps_cnt_data (bps_cnt_data),
    .tick_os      (tick_os),
    .tick_bit     (tick_bit),
    .bps_pending  (bps_pending),
    .bps_ack      (bps_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int baud_tab [16] = '{600, 1200, 1800, 2400, 3600, 4800, 7200, 9600,
                        19200, 38400, 14400, 28800, 57600, 76800, 115200, 230400};

  logic [3:0] cur_code;
  longint     n, m;
  bit         mdl_clr, e_os, e_bit;
  int         seq_err, ack_cnt, bit_cnt, exp_bit_cnt, os_seen;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_div(input logic [3:0] c);
    longint d;
    d = CLK_FREQ / baud_tab[c];
    return (d > 65535) ? 65535 : d;
  endfunction

  // Does the n-th enabled clock since the phase origin produce an oversample tick?
  function automatic bit os_hit(input logic [3:0] c, input longint k);
`ifdef UART_BAUD_FRAC_EN
    longint unsigned num, inc, a, b;
    num = longint'(baud_tab[c]) * OS * (64'd1 << ACC_W);
    inc = (2 * num + CLK_FREQ) / (2 * CLK_FREQ);
    a = (longint'(k) * inc) >> ACC_W;
    b = (longint'(k - 1) * inc) >> ACC_W;
    return a != b;
`else
    longint p;
    p = exp_div(c) / OS;
    if (p < 1) p = 1;
    return (k % p) == 0;
`endif
  endfunction

  task automatic cyc();
    bit en_s, clr_s;
    en_s  = enable;
    clr_s = mdl_clr;
    @(posedge clk);
    #1;
    if (clr_s) begin
      n = 0; m = 0; e_os = 0; e_bit = 0;
    end else if (en_s) begin
      n++;
      e_os = os_hit(cur_code, n);
      if (e_os) m++;
      e_bit = e_os && (m % OS == 0);
    end else begin
      e_os = 0; e_bit = 0;
    end
    if (tick_os !== e_os || tick_bit !== e_bit) seq_err++;
    if (bps_ack) ack_cnt++;
    if (tick_bit) bit_cnt++;
    if (tick_os) os_seen++;
    if (e_bit) exp_bit_cnt++;
  endtask

  task automatic apply_now(input logic [3:0] code);
    uart_bps   = {4'($urandom), code};
    bps_update = 1'b1;
    line_idle  = 1'b1;
    mdl_clr    = 1'b1;
    cyc();
    bps_update = 1'b0;
    check("apply_ack", bps_ack, 1);
    check("apply_no_tick", tick_os, 0);
    cyc();
    cur_code = code;
    mdl_clr  = 1'b0;
    check("apply_div", bps_cnt_data, exp_div(code));
    check("apply_ack_drop", bps_ack, 0);
  endtask

  initial begin
    cur_code = DEF; n = 0; m = 0; mdl_clr = 0; e_os = 0; e_bit = 0;
    seq_err = 0; ack_cnt = 0; bit_cnt = 0; exp_bit_cnt = 0; os_seen = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tick_os", tick_os, 0);
    check("rst_tick_bit", tick_bit, 0);
    check("rst_ack", bps_ack, 0);
    check("rst_pending", bps_pending, 0);
    check("rst_div", bps_cnt_data, 234);
    @(negedge clk) rst_n = 1'b1;

    // default rate, line_idle wiggling without requests must not matter
    repeat (15000) begin line_idle = 1'($urandom_range(0, 1)); cyc(); end
    check("def_seq", seq_err, 0);
    check("def_bits", bit_cnt, exp_bit_cnt);
    check("def_bits_seen", bit_cnt >= 60, 1);
    check("def_ack_none", ack_cnt, 0);

    apply_now(4'h7);
    check("div_9600", bps_cnt_data, 2812);
    seq_err = 0; bit_cnt = 0; exp_bit_cnt = 0;
    repeat (12000) cyc();
    check("c7_seq", seq_err, 0);
    check("c7_bits", bit_cnt, exp_bit_cnt);

    // deferred request while the line is busy
    ack_cnt = 0; seq_err = 0;
    uart_bps = 8'h5F; bps_update = 1'b1; line_idle = 1'b0;
    cyc();
    bps_update = 1'b0;
    check("wait_pending", bps_pending, 1);
    repeat (500) cyc();
    check("wait_pending_hold", bps_pending, 1);
    check("wait_old_div", bps_cnt_data, 2812);
    check("wait_old_rate", seq_err, 0);
    line_idle = 1'b1; mdl_clr = 1'b1;
    cyc();
    check("idle_ack", bps_ack, 1);
    check("idle_pending_clr", bps_pending, 0);
    cyc();
    cur_code = 4'hF; mdl_clr = 1'b0;
    check("div_230400", bps_cnt_data, 117);
    repeat (800) cyc();
    check("f_seq", seq_err, 0);
    check("f_ack_once", ack_cnt, 1);

    // last request wins
    ack_cnt = 0; seq_err = 0; line_idle = 1'b0;
    uart_bps = 8'h03; bps_update = 1'b1; cyc(); bps_update = 1'b0;
    repeat (50) cyc();
    uart_bps = 8'hA9; bps_update = 1'b1; cyc(); bps_update = 1'b0;
    repeat (50) cyc();
    check("two_pending", bps_pending, 1);
    line_idle = 1'b1; mdl_clr = 1'b1;
    cyc(); cyc();
    cur_code = 4'h9; mdl_clr = 1'b0;
    check("last_wins_div", bps_cnt_data, 703);
    repeat (500) cyc();
    check("last_wins_ack", ack_cnt, 1);
    check("last_wins_seq", seq_err, 0);

    // enable gap freezes the phase
    seq_err = 0;
    repeat (137) cyc();
    enable = 1'b0; os_seen = 0;
    repeat (100) cyc();
    check("gap_no_ticks", os_seen, 0);
    enable = 1'b1;
    repeat (600) cyc();
    check("gap_resume_seq", seq_err, 0);

    // randomized rate changes, including a same-code resync
    for (int i = 0; i < 6; i++) begin
      logic [3:0] code;
      code = (i == 3) ? cur_code : 4'($urandom_range(0, 15));
      apply_now(code);
      seq_err = 0;
      repeat ($urandom_range(300, 1500)) begin
        if ($urandom_range(0, 7) == 0) enable = ~enable;
        line_idle = 1'($urandom_range(0, 1));
        cyc();
      end
      enable = 1'b1;
      check("rand_seq", seq_err, 0);
    end

    // asynchronous reset while waiting discards the request
    uart_bps = 8'h05; bps_update = 1'b1; line_idle = 1'b0;
    cyc();
    bps_update = 1'b0;
    repeat (20) cyc();
    check("arst_pre_pending", bps_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pending", bps_pending, 0);
    check("arst_div", bps_cnt_data, 234);
    check("arst_tick", tick_os, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; line_idle = 1'b1;
    cur_code = DEF; n = 0; m = 0;
    ack_cnt = 0; seq_err = 0;
    repeat (500) cyc();
    check("arst_no_ack", ack_cnt, 0);
    check("arst_seq", seq_err, 0);
    check("arst_div_hold", bps_cnt_data, exp_div(DEF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
